nibble_serial_add_ctrl: RTL

Sequencer that sits directly upstream of the 4-bit adder and adds wide operands one nibble per cycle. It accepts a NIBBLES*4-bit operand pair plus carry-in over a valid/ready handshake. It feeds the adder nibble by nibble (LSB first) and chains the adder's carry-out back as the next carry-in. It collects the adder's sum nibbles and presents the wide result over a second valid/ready handshake.

---
 rtl/nibble_serial_add_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - nibble-serial sequencer driving an external 4-bit adder
//
// Accepts an operand pair plus carry-in on in_valid/in_ready and walks the
// operands through the external adder one nibble per cycle, LSB first. The
// adder's carry-out is chained into the next nibble. The assembled result is
// then offered on out_valid/out_ready.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid/in_ready      operand handshake
//   in_a, in_b, in_cin     operands (4*NIBBLES bits) and carry-in
//   add_a, add_b, add_cin  nibble and carry presented to the adder (0 outside RUN)
//   add_sum, add_cout      combinational return from the adder
//   out_valid/out_ready    result handshake
//   out_sum, out_cout      wide sum and carry out of the top nibble
//   out_ovf                signed overflow (only with SERIAL_ADD_OVF_EN defined)
//
// Optional macro: SERIAL_ADD_OVF_EN adds the out_ovf port.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    input  logic                   in_cin,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic                   out_ovf,
`endif
    output logic                   out_cout
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   res_q, res_d;
    logic           res_cout_q, res_cout_d;
    // res is built up nibble by nibble during RUN; out_sum is a separate copy
    // so the visible result only changes on entry to DONE.
    logic [W-1:0]   out_sum_q, out_sum_d;
`ifdef SERIAL_ADD_OVF_EN
    logic           ovf_q, ovf_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            opa_q      <= '0;
            opb_q      <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            res_q      <= '0;
            res_cout_q <= 1'b0;
            out_sum_q  <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            res_q      <= res_d;
            res_cout_q <= res_cout_d;
            out_sum_q  <= out_sum_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        res_cout_d = res_cout_q;
        out_sum_d  = out_sum_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d      = ovf_q;
`endif
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        add_a      = 4'd0;
        add_b      = 4'd0;
        add_cin    = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    opa_d   = in_a;
                    opb_d   = in_b;
                    carry_d = in_cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                add_a   = opa_q[4*cnt_q +: 4];
                add_b   = opb_q[4*cnt_q +: 4];
                add_cin = carry_q;
                res_d[4*cnt_q +: 4] = add_sum;
                carry_d = add_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // res_d already holds the top nibble here, so the
                    // published copies see the complete result.
                    res_cout_d = add_cout;
                    out_sum_d  = res_d;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d = (opa_q[W-1] == opb_q[W-1]) && (res_d[W-1] != opa_q[W-1]);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_sum  = out_sum_q;
    assign out_cout = res_cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign out_ovf  = ovf_q;
`endif

endmodule
